// File: rtl/calc_req_arbiter.sv
// Round-robin front end for a shared combinational 4-bit signed calculator.
// Each accepted operation is held on the calculator for SETTLE cycles, then the result is returned over a valid/ready response.
module calc_req_arbiter #(
    parameter int SETTLE = 2,
    parameter int CNT_W  = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [7:0] req_Ain,
    input  logic [7:0] req_Bin,
    input  logic [3:0] req_sel,
    input  logic [1:0] req_s0,
    input  logic [1:0] req_s1,
    output logic [3:0] calc_Ain,
    output logic [3:0] calc_Bin,
    output logic [1:0] calc_sel,
    output logic       calc_s0,
    output logic       calc_s1,
    output logic       calc_Reset,
    input  logic [8:0] calc_ALUout,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [8:0] rsp_data,
    output logic       rsp_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_rr_ptr;
    logic [CNT_W-1:0]  r_cnt;
    logic signed [3:0] r_ain;
    logic signed [3:0] r_bin;
    logic [1:0]        r_sel;
    logic              r_s0;
    logic              r_s1;
    logic              r_id;
    logic [8:0]        r_data;
    logic              r_err;

    logic [1:0]        w_grant;
    logic              w_gid;
    logic              w_accept;
    logic signed [3:0] w_ain;
    logic signed [3:0] w_bin;
    logic [1:0]        w_sel;
    logic              w_s0;
    logic              w_s1;
    logic              w_div0;
    logic              w_settled;

    // Grant only while idle and out of reset; on contention rr_ptr picks the winner.
    always_comb begin
        w_grant = 2'b00;
        if (r_state == IDLE && !Reset) begin
            case (req_valid)
                2'b01:   w_grant = 2'b01;
                2'b10:   w_grant = 2'b10;
                2'b11:   w_grant = r_rr_ptr ? 2'b10 : 2'b01;
                default: w_grant = 2'b00;
            endcase
        end
    end

    assign w_gid     = w_grant[1];
    assign w_accept  = |w_grant;
    assign w_ain     = w_gid ? req_Ain[7:4] : req_Ain[3:0];
    assign w_bin     = w_gid ? req_Bin[7:4] : req_Bin[3:0];
    assign w_sel     = w_gid ? req_sel[3:2] : req_sel[1:0];
    assign w_s0      = req_s0[w_gid];
    assign w_s1      = req_s1[w_gid];
    assign w_div0    = (w_sel == 2'b10) && (w_bin == 4'sd0);
    assign w_settled = (r_cnt == CNT_W'(SETTLE - 1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_div0 ? RESP : ISSUE;
            ISSUE:   if (w_settled) w_next = RESP;
            RESP:    if (rsp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rr_ptr <= 1'b0;
            r_cnt    <= '0;
            r_ain    <= '0;
            r_bin    <= '0;
            r_sel    <= '0;
            r_s0     <= 1'b0;
            r_s1     <= 1'b0;
            r_id     <= 1'b0;
            r_data   <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_ain    <= w_ain;
                        r_bin    <= w_bin;
                        r_sel    <= w_sel;
                        r_s0     <= w_s0;
                        r_s1     <= w_s1;
                        r_id     <= w_gid;
                        r_rr_ptr <= ~w_gid;
                        r_cnt    <= '0;
                        // Divide by zero is answered without ever enabling the calculator.
                        if (w_div0) begin
                            r_data <= '0;
                            r_err  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_settled) begin
                        r_data <= calc_ALUout;
                        r_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign calc_Ain   = r_ain;
    assign calc_Bin   = r_bin;
    assign calc_sel   = r_sel;
    assign calc_s0    = r_s0;
    assign calc_s1    = r_s1;
    assign calc_Reset = (r_state != ISSUE);
    assign rsp_valid  = (r_state == RESP);
    assign rsp_id     = r_id;
    assign rsp_data   = r_data;
    assign rsp_err    = r_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_calc_req_arbiter.sv
// Directed bench for calc_req_arbiter with a small add-only calculator stub on the datapath side.
module tb_calc_req_arbiter;

    logic       Clk;
    logic       Reset;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_Ain;
    logic [7:0] req_Bin;
    logic [3:0] req_sel;
    logic [1:0] req_s0;
    logic [1:0] req_s1;
    logic [3:0] calc_Ain;
    logic [3:0] calc_Bin;
    logic [1:0] calc_sel;
    logic       calc_s0;
    logic       calc_s1;
    logic       calc_Reset;
    logic [8:0] calc_ALUout;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [8:0] rsp_data;
    logic       rsp_err;
    logic       busy;

    int n_vec  = 0;
    int n_miss = 0;

    calc_req_arbiter #(.SETTLE(2), .CNT_W(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_Ain(req_Ain), .req_Bin(req_Bin), .req_sel(req_sel),
        .req_s0(req_s0), .req_s1(req_s1),
        .calc_Ain(calc_Ain), .calc_Bin(calc_Bin), .calc_sel(calc_sel),
        .calc_s0(calc_s0), .calc_s1(calc_s1), .calc_Reset(calc_Reset),
        .calc_ALUout(calc_ALUout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    // Calculator stub: signed add for sel 00, a packed tag otherwise, zero while held in reset.
    always_comb begin
        if (calc_Reset)
            calc_ALUout = 9'h000;
        else if (calc_sel == 2'b00)
            calc_ALUout = {{5{calc_Ain[3]}}, calc_Ain} + {{5{calc_Bin[3]}}, calc_Bin};
        else
            calc_ALUout = {calc_s1, calc_s0, calc_sel, 1'b1, calc_Bin};
    end

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] exp_grant [4];
    logic       exp_id    [4];
    logic [8:0] exp_data  [4];

    initial begin
        exp_grant[0] = 2'b10; exp_id[0] = 1'b1; exp_data[0] = 9'd7;
        exp_grant[1] = 2'b01; exp_id[1] = 1'b0; exp_data[1] = 9'd2;
        exp_grant[2] = 2'b10; exp_id[2] = 1'b1; exp_data[2] = 9'd7;
        exp_grant[3] = 2'b01; exp_id[3] = 1'b0; exp_data[3] = 9'd2;

        Reset = 1'b1; req_valid = 2'b00; req_Ain = '0; req_Bin = '0; req_sel = '0;
        req_s0 = '0; req_s1 = '0; rsp_ready = 1'b0;
        tick(); tick();
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_calc_Reset", calc_Reset, 1'b1);
        chk("rst_rsp_data", rsp_data, 9'h000);
        chk("rst_calc_Ain", calc_Ain, 4'h0);

        // Single add from requester 0
        Reset = 1'b0;
        req_valid = 2'b01; req_Ain = 8'h03; req_Bin = 8'h02; req_sel = 4'b0000; req_s0 = 2'b01;
        #1 chk("t1_grant", req_ready, 2'b01);
        tick();
        req_valid = 2'b00; req_s0 = 2'b00;
        chk("t1_issue0_ain", calc_Ain, 4'd3);
        chk("t1_issue0_creset", calc_Reset, 1'b0);
        chk("t1_issue0_s0", calc_s0, 1'b1);
        chk("t1_issue0_busy", busy, 1'b1);
        chk("t1_issue0_valid", rsp_valid, 1'b0);
        tick();
        chk("t1_issue1_ain", calc_Ain, 4'd3);
        chk("t1_issue1_valid", rsp_valid, 1'b0);
        tick();
        chk("t1_rsp_valid", rsp_valid, 1'b1);
        chk("t1_rsp_id", rsp_id, 1'b0);
        chk("t1_rsp_data", rsp_data, 9'd5);
        chk("t1_rsp_err", rsp_err, 1'b0);
        chk("t1_rsp_creset", calc_Reset, 1'b1);
        rsp_ready = 1'b1;
        tick();
        chk("t1_back_idle", rsp_valid, 1'b0);

        // Both requesters valid continuously: grants must alternate
        req_valid = 2'b11; req_Ain = 8'h21; req_Bin = 8'h51; req_sel = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("t2_grant%0d", i), req_ready, exp_grant[i]);
            tick(); tick(); tick();
            chk($sformatf("t2_id%0d", i), rsp_id, exp_id[i]);
            chk($sformatf("t2_data%0d", i), rsp_data, exp_data[i]);
            chk($sformatf("t2_ready_in_resp%0d", i), req_ready, 2'b00);
            tick();
        end

        // Divide by zero from requester 1
        req_valid = 2'b10; req_Ain = 8'h61; req_Bin = 8'h01; req_sel = 4'b1000;
        #1 chk("t3_grant", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("t3_rsp_valid", rsp_valid, 1'b1);
        chk("t3_rsp_err", rsp_err, 1'b1);
        chk("t3_rsp_data", rsp_data, 9'h000);
        chk("t3_rsp_id", rsp_id, 1'b1);
        chk("t3_creset_resp", calc_Reset, 1'b1);
        tick();
        chk("t3_creset_idle", calc_Reset, 1'b1);
        chk("t3_idle", busy, 1'b0);

        // Back-pressure: -3 + 2 = -1, response held while rsp_ready is low
        rsp_ready = 1'b0;
        req_valid = 2'b01; req_Ain = 8'h0D; req_Bin = 8'h02; req_sel = 4'b0000;
        #1 chk("t4_grant", req_ready, 2'b01);
        tick(); tick(); tick();
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("t4_hold_valid%0d", i), rsp_valid, 1'b1);
            chk($sformatf("t4_hold_data%0d", i), rsp_data, 9'h1FF);
            chk($sformatf("t4_hold_id%0d", i), rsp_id, 1'b0);
            chk($sformatf("t4_hold_ready%0d", i), req_ready, 2'b00);
            chk($sformatf("t4_hold_busy%0d", i), busy, 1'b1);
            tick();
        end
        rsp_ready = 1'b1;
        #1 chk("t4_handshake_ready", req_ready, 2'b00);
        tick();
        chk("t4_next_grant", req_ready, 2'b10);

        // Reset while an operation is in ISSUE
        req_Ain = 8'h50; req_Bin = 8'h30;
        tick();
        chk("t5_in_issue", calc_Reset, 1'b0);
        Reset = 1'b1; req_valid = 2'b00;
        tick();
        chk("t5_busy", busy, 1'b0);
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_calc_Reset", calc_Reset, 1'b1);
        chk("t5_calc_Ain", calc_Ain, 4'h0);
        chk("t5_rsp_data", rsp_data, 9'h000);
        chk("t5_rsp_id", rsp_id, 1'b0);
        Reset = 1'b0;
        tick(); tick(); tick();
        chk("t5_no_rsp", rsp_valid, 1'b0);

        // Operand change after accept is ignored
        req_valid = 2'b11; req_Ain = 8'h04; req_Bin = 8'h01; req_sel = 4'b0000;
        #1 chk("t5_grant_r0", req_ready, 2'b01);
        tick();
        req_Ain = 8'h07; req_valid = 2'b00;
        #1 chk("t6_issue0_ain", calc_Ain, 4'd4);
        tick();
        chk("t6_issue1_ain", calc_Ain, 4'd4);
        tick();
        chk("t6_rsp_data", rsp_data, 9'd5);
        chk("t6_rsp_valid", rsp_valid, 1'b1);
        tick();
        chk("t6_done", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
